// File: rtl/demux_1t32_32_pkg.sv
// rtl/demux_1t32_32_pkg.sv - shared constants for the 1-to-32 lane demux
//
// Purpose: single source for the demux data width, select width and lane
// count, so the top, the decoder and any integrating logic agree.
// Ports: none (package).

package demux_1t32_32_pkg;

    localparam int DEMUX_DATA_W = 32;
    localparam int DEMUX_SEL_W  = 5;
    localparam int DEMUX_N      = 32;

endpackage : demux_1t32_32_pkg

// File: rtl/dec_5t32.sv
// rtl/dec_5t32.sv - combinational one-hot decoder for the lane select
//
// Purpose: turns a binary lane index into a one-hot lane mask.
// Ports:
//   sel    - binary lane index (SEL_W bits)
//   onehot - one-hot decode, bit sel set, all others clear (N bits)

module dec_5t32
    import demux_1t32_32_pkg::*;
#(
    parameter int SEL_W = DEMUX_SEL_W,
    parameter int N     = 2 ** SEL_W
) (
    input  logic [SEL_W-1:0] sel,
    output logic [N-1:0]     onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule : dec_5t32

// File: rtl/demux_1t32_32.sv
// rtl/demux_1t32_32.sv - registered 1-to-32 data demux with one-hot lane flag
//
// Purpose: every clock, routes d to lane s of y_arr and zeroes all other
// lanes; y_sel flags which lane is carrying data. Outputs are registered
// (one clock latency) and cleared asynchronously by rst.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   s     - destination lane index (SEL_W bits)
//   d     - data word (DATA_W bits)
//   y_arr - flattened lanes, lane i at [DATA_W*i +: DATA_W] (N*DATA_W bits)
//   y_sel - registered one-hot select (N bits)

module demux_1t32_32
    import demux_1t32_32_pkg::*;
#(
    parameter int DATA_W = DEMUX_DATA_W,
    parameter int SEL_W  = DEMUX_SEL_W,
    parameter int N      = 2 ** SEL_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SEL_W-1:0]    s,
    input  logic [DATA_W-1:0]   d,
    output logic [N*DATA_W-1:0] y_arr,
    output logic [N-1:0]        y_sel
);

    logic [N-1:0] dec;

    // One decode drives both the lane gating and y_sel, so the data lane and
    // its flag can never disagree.
    dec_5t32 #(
        .SEL_W (SEL_W),
        .N     (N)
    ) u_dec (
        .sel    (s),
        .onehot (dec)
    );

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DATA_W-1:0] gated;
        logic [DATA_W-1:0] lane_q;
        logic              sel_q;

        // Unselected lanes load zero rather than holding stale data.
        assign gated = d & {DATA_W{dec[i]}};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lane_q <= '0;
                sel_q  <= 1'b0;
            end else begin
                lane_q <= gated;
                sel_q  <= dec[i];
            end
        end

        assign y_arr[DATA_W*i +: DATA_W] = lane_q;
        assign y_sel[i]                  = sel_q;
    end

endmodule : demux_1t32_32

// File: tb/tb_demux_1t32_32.sv
// tb/tb_demux_1t32_32.sv - directed self-checking bench for demux_1t32_32

module tb_demux_1t32_32;

    logic          clk;
    logic          rst;
    logic [4:0]    s;
    logic [31:0]   d;
    logic [1023:0] y_arr;
    logic [31:0]   y_sel;

    int n_checks;
    int n_fails;

    demux_1t32_32 dut (
        .clk   (clk),
        .rst   (rst),
        .s     (s),
        .d     (d),
        .y_arr (y_arr),
        .y_sel (y_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lane(input int i);
        return y_arr[32*i +: 32];
    endfunction

    // Whole-output check: when active, lane es must hold ed and y_sel must be
    // exactly bit es; every other lane and bit must be zero.
    task automatic check_all(input string tag, input bit active, input int es, input logic [31:0] ed);
        logic [31:0] exp_sel;
        exp_sel = active ? (32'h1 << es) : 32'h0;
        for (int i = 0; i < 32; i++)
            check_eq($sformatf("%s lane%0d", tag, i), lane(i), (active && i == es) ? ed : 32'h0);
        check_eq($sformatf("%s y_sel", tag), y_sel, exp_sel);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;

        // Asynchronous reset before any clock edge
        rst = 1'b1;
        s   = 5'h0;
        d   = 32'h0;
        #2;
        check_all("reset_async", 1'b0, 0, 32'h0);

        // Outputs stay clear through edges while rst is held
        s = 5'd3;
        d = 32'h0000_0123;
        tick();
        tick();
        check_all("reset_hold", 1'b0, 0, 32'h0);

        // Top lane, first edge after release
        @(negedge clk);
        rst = 1'b0;
        s   = 5'b11111;
        d   = 32'h1;
        tick();
        check_eq("top_lane31", lane(31), 32'h1);
        check_eq("top_y_sel", y_sel, 32'h8000_0000);
        check_all("top", 1'b1, 31, 32'h1);

        // Re-route to lane 1; lane 31 must clear
        s = 5'b00001;
        d = 32'hFFFF_FFFF;
        tick();
        check_eq("reroute_lane1", lane(1), 32'hFFFF_FFFF);
        check_eq("reroute_lane31", lane(31), 32'h0);
        check_eq("reroute_y_sel", y_sel, 32'h0000_0002);
        check_all("reroute", 1'b1, 1, 32'hFFFF_FFFF);

        // Inputs changing after the edge must not reach the outputs
        s = 5'd20;
        d = 32'h1357_9BDF;
        #2;
        check_eq("nocomb_lane1", lane(1), 32'hFFFF_FFFF);
        check_eq("nocomb_lane20", lane(20), 32'h0);
        check_eq("nocomb_y_sel", y_sel, 32'h0000_0002);

        // Full sweep of every lane index
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            s = k[4:0];
            d = 32'hA5A5_0000 + k;
            tick();
            check_all($sformatf("sweep%0d", k), 1'b1, k, 32'hA5A5_0000 + k);
        end

        // Glitches between edges: only the values present at the edge count
        @(negedge clk);
        s = 5'd4;  d = 32'h4444_4444;
        #1;
        s = 5'd17; d = 32'h1717_1717;
        #1;
        s = 5'd9;  d = 32'h0909_0909;
        tick();
        check_all("glitch", 1'b1, 9, 32'h0909_0909);

        // Mid-operation reset pulse between edges
        @(negedge clk);
        s = 5'd7;
        d = 32'hDEAD_BEEF;
        tick();
        check_eq("mid_load_lane7", lane(7), 32'hDEAD_BEEF);
        check_eq("mid_load_y_sel", y_sel, 32'h0000_0080);
        #1;
        rst = 1'b1;
        #1;
        check_all("mid_reset_async", 1'b0, 0, 32'h0);
        s = 5'd22;
        d = 32'h0BAD_F00D;
        #1;
        rst = 1'b0;
        tick();
        check_all("mid_reset_release", 1'b1, 22, 32'h0BAD_F00D);

        // Zero data still flags the selected lane
        @(negedge clk);
        s = 5'd12;
        d = 32'h0;
        tick();
        check_eq("zero_y_sel", y_sel, 32'h0000_1000);
        check_all("zero", 1'b1, 12, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_demux_1t32_32
